matrix_stream_load: RTL and testbench

MATRIX_STREAM_LOAD -- requirements
Module: matrix_stream_load

---
 rtl/matrix_stream_load_pkg.sv | 14 +
 rtl/matrix_store.sv | 45 ++++
 rtl/matrix_stream_load.sv | 178 +++++++++++++++++
 tb/tb_matrix_stream_load.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_load_pkg.sv
// rtl/matrix_stream_load_pkg.sv - shared state encoding and default sizing for the matrix loader
package matrix_stream_load_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_MAX_DIM = 16;
   localparam int DEF_IDX_W   = 8;

endpackage

// File: rtl/matrix_store.sv
// rtl/matrix_store.sv - MAX_DIM x MAX_DIM entry store, one sync write port and one registered read port
module matrix_store #(
   parameter int DATA_W  = 32,
   parameter int MAX_DIM = 16,
   parameter int ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [MAX_DIM*MAX_DIM];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   // Array itself is never reset; only the read register is.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/matrix_stream_load.sv
// rtl/matrix_stream_load.sv - streams an m x n matrix into storage in row- or column-major order
module matrix_stream_load
   import matrix_stream_load_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MAX_DIM = DEF_MAX_DIM,
   parameter int IDX_W   = DEF_IDX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [IDX_W-1:0]  m_dim,
   input  logic [IDX_W-1:0]  n_dim,
   input  logic              transpose,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_m,
   input  logic [IDX_W-1:0]  rd_n,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int CNT_W  = 2 * IDX_W;
   localparam int ADDR_W = (MAX_DIM > 1) ? $clog2(MAX_DIM * MAX_DIM) : 1;
   localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(MAX_DIM);
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(MAX_DIM);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  m_q, m_d;
   logic [IDX_W-1:0]  n_q, n_d;
   logic              tr_q, tr_d;
   logic [IDX_W-1:0]  row_q, row_d;
   logic [IDX_W-1:0]  col_q, col_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_oob_q, rd_oob_d;

   logic              start_ok;
   logic              accept;
   logic              rd_oob_now;
   logic [CNT_W-1:0]  total;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] store_rd_data;

   assign start_ok = (m_dim != '0) && (m_dim <= MAX_IDX) &&
                     (n_dim != '0) && (n_dim <= MAX_IDX);
   assign total    = CNT_W'(m_q) * CNT_W'(n_q);

   assign in_ready = (state_q == ST_LOAD) && !abort;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q == ST_LOAD);
   assign done     = (state_q == ST_FINISH);
   assign err      = err_q;
   assign rd_valid = rd_valid_q;

   // Out-of-range reads are judged against the dims latched at the last accepted start.
   assign rd_oob_now = (rd_m >= m_q) || (rd_n >= n_q);
   assign wr_addr    = ADDR_W'(row_q) * ROW_PITCH + ADDR_W'(col_q);
   assign rd_addr    = rd_oob_now ? '0 : (ADDR_W'(rd_m) * ROW_PITCH + ADDR_W'(rd_n));

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      n_d        = n_q;
      tr_d       = tr_q;
      row_d      = row_q;
      col_d      = col_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      rd_valid_d = rd_en;
      rd_oob_d   = rd_en ? rd_oob_now : rd_oob_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (start_ok) begin
                  m_d     = m_dim;
                  n_d     = n_dim;
                  tr_d    = transpose;
                  row_d   = '0;
                  col_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (accept) begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_d == total) begin
                  state_d = ST_FINISH;
               end
               // The fast index wraps at its dimension and carries into the slow one.
               if (!tr_q) begin
                  if (col_q == n_q - IDX_ONE) begin
                     col_d = '0;
                     row_d = row_q + IDX_ONE;
                  end else begin
                     col_d = col_q + IDX_ONE;
                  end
               end else begin
                  if (row_q == m_q - IDX_ONE) begin
                     row_d = '0;
                     col_d = col_q + IDX_ONE;
                  end else begin
                     row_d = row_q + IDX_ONE;
                  end
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         m_q        <= '0;
         n_q        <= '0;
         tr_q       <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_oob_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         n_q        <= n_d;
         tr_q       <= tr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
         rd_oob_q   <= rd_oob_d;
      end
   end

   matrix_store #(
      .DATA_W  (DATA_W),
      .MAX_DIM (MAX_DIM),
      .ADDR_W  (ADDR_W)
   ) u_store (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept),
      .wr_addr (wr_addr),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (store_rd_data)
   );

   // Both terms only change on a read request, so rd_data holds between reads.
   assign rd_data = rd_oob_q ? '0 : store_rd_data;

endmodule

// File: tb/tb_matrix_stream_load.sv
// tb/tb_matrix_stream_load.sv - directed and randomized bench for matrix_stream_load with a reference model
module tb_matrix_stream_load;

   localparam int DW = 32;
   localparam int MD = 16;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [IW-1:0] m_dim, n_dim;
   logic          transpose;
   logic          abort;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready, busy, done, err;
   logic          rd_en;
   logic [IW-1:0] rd_m, rd_n;
   logic [DW-1:0] rd_data;
   logic          rd_valid;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mdl [MD][MD];
   bit            written [MD][MD];
   int            lm = 0;
   int            ln = 0;
   bit            cur_tr = 1'b0;
   logic [DW-1:0] dq [$];

   always #5 clk = ~clk;

   matrix_stream_load #(.DATA_W(DW), .MAX_DIM(MD), .IDX_W(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .m_dim     (m_dim),
      .n_dim     (n_dim),
      .transpose (transpose),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rd_en     (rd_en),
      .rd_m      (rd_m),
      .rd_n      (rd_n),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void clear_model();
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++)
            written[r][c] = 1'b0;
   endfunction

   // Beat k lands at (k / n, k % n) row-major or (k % m, k / m) column-major.
   function automatic void beat_loc(input int k, output int r, output int c);
      if (cur_tr) begin
         r = k % lm;
         c = k / lm;
      end else begin
         r = k / ln;
         c = k % ln;
      end
   endfunction

   task automatic start_load(input int m, input int n, input bit tr);
      start = 1'b1; m_dim = IW'(m); n_dim = IW'(n); transpose = tr;
      tick();
      start = 1'b0;
      lm = m; ln = n; cur_tr = tr;
      chk("start_busy", busy, 1);
      chk("start_err", err, 0);
   endtask

   task automatic bad_start(input int m, input int n);
      start = 1'b1; m_dim = IW'(m); n_dim = IW'(n); transpose = 1'b0;
      tick();
      start = 1'b0;
      chk("bad_err_pulse", err, 1);
      chk("bad_busy", busy, 0);
      tick();
      chk("bad_err_clear", err, 0);
      chk("bad_busy2", busy, 0);
   endtask

   // gap: 0 continuous, 1 every other cycle, 2 random. abort_after < 0 means run to completion.
   task automatic stream(input int gap, input int abort_after, input bit poke_start);
      int k = 0;
      int cyc = 0;
      int total = lm * ln;
      int r, c;
      bit valid, do_rd, probe_ok;
      logic [DW-1:0] old_val;
      while (k < total && cyc < 4000) begin
         if (abort_after >= 0 && k == abort_after) begin
            abort = 1'b1; in_valid = 1'b1; in_data = $urandom();
            #1;
            chk("abort_in_ready", in_ready, 0);
            tick();
            abort = 1'b0; in_valid = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            return;
         end
         valid = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         in_valid = valid;
         in_data  = valid ? dq[k] : $urandom();
         beat_loc(k, r, c);
         do_rd    = ($urandom_range(0, 3) == 0);
         rd_en    = do_rd; rd_m = IW'(r); rd_n = IW'(c);
         old_val  = mdl[r][c];
         probe_ok = written[r][c];
         if (poke_start && cyc == 1) begin
            start = 1'b1; m_dim = '0; n_dim = '0;
         end
         #1;
         chk("in_ready", in_ready, 1);
         tick();
         if (poke_start && cyc == 1) chk("start_in_load_err", err, 0);
         start = 1'b0; rd_en = 1'b0;
         if (do_rd) begin
            chk("probe_rd_valid", rd_valid, 1);
            if (probe_ok) chk("probe_old_data", rd_data, old_val);
         end
         if (valid) begin
            mdl[r][c] = dq[k];
            written[r][c] = 1'b1;
            k++;
         end
         cyc++;
         if (k < total) begin
            chk("mid_done", done, 0);
            chk("mid_busy", busy, 1);
         end else begin
            chk("fin_done", done, 1);
            chk("fin_busy", busy, 0);
            chk("fin_in_ready", in_ready, 0);
         end
      end
      if (k < total) begin
         chk("stream_timeout", k, total);
         in_valid = 1'b0;
         return;
      end
      in_valid = 1'b1; in_data = $urandom();
      tick();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic rd_const(input int r, input int c, input logic [DW-1:0] exp, input string tag);
      rd_en = 1'b1; rd_m = IW'(r); rd_n = IW'(c);
      tick();
      rd_en = 1'b0;
      chk({tag, "_valid"}, rd_valid, 1);
      chk(tag, rd_data, exp);
   endtask

   task automatic rd_model(input int r, input int c, input bit check_hold);
      logic [DW-1:0] exp;
      if (r >= lm || c >= ln) exp = '0;
      else if (written[r][c]) exp = mdl[r][c];
      else return;
      rd_const(r, c, exp, "rd_model");
      if (check_hold) begin
         tick();
         chk("rd_hold_valid", rd_valid, 0);
         chk("rd_hold_data", rd_data, exp);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; m_dim = '0; n_dim = '0; transpose = 1'b0;
      abort = 1'b0; in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_m = '0; rd_n = '0;
      clear_model();
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      tick(); tick();
      reset = 1'b0;
      tick();
      rd_const(0, 0, 32'h0, "rd_after_reset");

      // Row-major 2x3 load of 1..6.
      start_load(2, 3, 1'b0);
      dq.delete();
      for (int i = 0; i < 6; i++) dq.push_back(DW'(i + 1));
      stream(0, -1, 1'b0);
      rd_const(1, 0, 32'd4, "rm_1_0");
      rd_const(0, 2, 32'd3, "rm_0_2");
      rd_model(1, 2, 1'b1);
      rd_const(2, 0, 32'd0, "rm_oob_row");
      rd_const(0, 3, 32'd0, "rm_oob_col");

      // Column-major 2x3 load of 1..6.
      start_load(2, 3, 1'b1);
      stream(0, -1, 1'b0);
      rd_const(1, 0, 32'd2, "cm_1_0");
      rd_const(0, 2, 32'd5, "cm_0_2");

      bad_start(0, 4);
      bad_start(17, 1);
      bad_start(3, 0);

      // 4x4 with in_valid toggling; a stray start during the load must be ignored.
      start_load(4, 4, 1'b0);
      dq.delete();
      for (int i = 0; i < 16; i++) dq.push_back($urandom());
      stream(1, -1, 1'b1);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            rd_model(r, c, 1'b0);

      // Abort after 5 of 9, then reload zeros.
      start_load(3, 3, 1'b0);
      dq.delete();
      for (int i = 0; i < 9; i++) dq.push_back(32'hA000_0000 + DW'(i + 1));
      stream(0, 5, 1'b0);
      rd_const(1, 1, 32'hA000_0005, "abort_1_1");
      rd_model(0, 2, 1'b0);
      start_load(3, 3, 1'b0);
      dq.delete();
      for (int i = 0; i < 9; i++) dq.push_back('0);
      stream(0, -1, 1'b0);
      rd_const(2, 2, 32'h0, "reload_2_2");

      // Reset in the middle of a load, then a 1x1 load.
      start_load(2, 2, 1'b0);
      in_valid = 1'b1; in_data = 32'h1111_1111;
      tick();
      in_data = 32'h2222_2222;
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_done", done, 0);
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
      lm = 0; ln = 0;
      clear_model();
      tick();
      chk("midrst_done_after", done, 0);
      start_load(1, 1, 1'b0);
      dq.delete();
      dq.push_back(32'hDEAD_BEEF);
      stream(0, -1, 1'b0);
      rd_const(0, 0, 32'hDEAD_BEEF, "one_0_0");
      rd_const(0, 1, 32'h0, "one_0_1");

      // Full-size boundary load, then random loads.
      start_load(MD, MD, 1'($urandom_range(0, 1)));
      dq.delete();
      for (int i = 0; i < MD * MD; i++) dq.push_back($urandom());
      stream(2, -1, 1'b0);
      rd_model(MD - 1, MD - 1, 1'b0);
      rd_model(0, MD - 1, 1'b0);
      rd_const(MD, 0, 32'h0, "full_oob");
      for (int t = 0; t < 4; t++) begin
         int m = $urandom_range(1, MD);
         int n = $urandom_range(1, MD);
         start_load(m, n, 1'($urandom_range(0, 1)));
         dq.delete();
         for (int i = 0; i < m * n; i++) dq.push_back($urandom());
         stream($urandom_range(0, 2), -1, 1'b0);
         for (int j = 0; j < 12; j++)
            rd_model($urandom_range(0, m - 1), $urandom_range(0, n - 1), (j == 0));
         rd_model(m, $urandom_range(0, MD - 1), 1'b0);
         rd_model($urandom_range(0, MD - 1), n, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
